// File: rtl/uart_frame_rx_if.sv
// -----------------------------------------------------------------------------
// uart_frame_rx_if
// Byte stream carrying unstuffed frame payload from the UART frame receiver to
// its consumer.
//   m_data  : payload byte (source -> sink)
//   m_valid : m_data holds a byte (source -> sink)
//   m_last  : current byte is the final byte of the frame (source -> sink)
//   m_ready : sink accepts the byte when m_valid and m_ready are both high
// -----------------------------------------------------------------------------
interface uart_frame_rx_if;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_ready;

    modport master (
        output m_data,
        output m_valid,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/uart_frame_rx.sv
// -----------------------------------------------------------------------------
// uart_frame_rx
// UART (8N1, LSB first) receiver with SOM/EOM frame parsing, ESC byte
// unstuffing and a store-and-forward payload buffer. Only complete frames are
// streamed out; malformed, overlong or empty frames produce no output.
//
// Ports
//   clk          : system clock, single domain
//   rst_n        : synchronous reset, ACTIVE HIGH (name is historical)
//   uart_rx      : asynchronous serial input, idles high
//   m            : payload stream (uart_frame_rx_if.master)
//   frame_len    : length of the frame being streamed, held until next frame
//   frame_done   : 1-cycle pulse when a valid frame has been captured
//   err_framing  : 1-cycle pulse when a stop bit is sampled low
//   err_overflow : 1-cycle pulse when a frame exceeds MAX_LEN payload bytes
//   err_dropped  : 1-cycle pulse when a byte arrives while the buffer drains
//   busy         : high while a frame is being received or drained
// -----------------------------------------------------------------------------
module uart_frame_rx #(
    parameter int         CLK_FREQ  = 27_000_000,
    parameter int         BAUD_RATE = 115_200,
    parameter int         MAX_LEN   = 64,
    parameter logic [7:0] SOM       = 8'h01,
    parameter logic [7:0] EOM       = 8'hFF,
    parameter logic [7:0] ESC       = 8'h7D
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         uart_rx,
    uart_frame_rx_if.master              m,
    output logic [$clog2(MAX_LEN+1)-1:0] frame_len,
    output logic                         frame_done,
    output logic                         err_framing,
    output logic                         err_overflow,
    output logic                         err_dropped,
    output logic                         busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT + 1);
    localparam int PW           = $clog2(MAX_LEN);
    localparam int CNT_W        = PW + 1;
    localparam int LW           = $clog2(MAX_LEN + 1);

    localparam logic [CW-1:0]    BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]    HALF_LAST = CW'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_LEN);
    localparam logic [7:0]       UNSTUFF   = 8'h20;

    typedef enum logic [2:0] {
        R_IDLE  = 3'd0,
        R_START = 3'd1,
        R_DATA  = 3'd2,
        R_STOP  = 3'd3,
        R_WAIT  = 3'd4
    } rx_state_t;

    typedef enum logic [1:0] {
        P_HUNT  = 2'd0,
        P_BODY  = 2'd1,
        P_ESC   = 2'd2,
        P_DRAIN = 2'd3
    } p_state_t;

    // ---------------- bit engine state ----------------
    logic            r_sync1;
    logic            r_sync2;
    rx_state_t       r_rx_state;
    logic [CW-1:0]   r_clk_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic            r_byte_stb;
    logic [7:0]      r_byte;
    logic            r_frm_err;

    // ---------------- parser / buffer state ----------------
    p_state_t        r_p_state;
    logic [CNT_W-1:0] r_count;
    logic [PW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_frame_len;
    logic            r_frame_done;
    logic            r_err_ovf;
    logic            r_err_drop;
    logic            r_busy;
    logic [7:0]      r_m_data;
    logic            r_m_valid;
    logic            r_m_last;
    logic [7:0]      r_mem [MAX_LEN];

    logic            w_rx;
    logic            w_is_som;
    logic            w_is_eom;
    logic            w_is_esc;
    logic            w_full;
    logic            w_wr_en;
    logic [7:0]      w_wr_data;
    logic [PW-1:0]   w_wr_addr;
    logic [7:0]      w_rd_byte;
    logic            w_rd_last;
    logic            w_hs;

    assign w_rx      = r_sync2;
    assign w_is_som  = (r_byte == SOM);
    assign w_is_eom  = (r_byte == EOM);
    assign w_is_esc  = (r_byte == ESC);
    assign w_full    = (r_count == CNT_MAX);
    assign w_wr_addr = r_count[PW-1:0];
    assign w_rd_byte = r_mem[r_rd_ptr];
    // The byte being loaded at r_rd_ptr is the last one when ptr+1 == length.
    assign w_rd_last = ((LW'(r_rd_ptr) + LW'(1)) == r_frame_len);
    assign w_hs      = r_m_valid & m.m_ready;

    // Two-flop synchroniser for the asynchronous serial line (idle high).
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= uart_rx;
            r_sync2 <= r_sync1;
        end
    end

    // Bit engine: start detection, mid-bit sampling, stop check, byte strobe.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_rx_state <= R_IDLE;
            r_clk_cnt  <= '0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'h00;
            r_byte_stb <= 1'b0;
            r_byte     <= 8'h00;
            r_frm_err  <= 1'b0;
        end else begin
            r_byte_stb <= 1'b0;
            r_frm_err  <= 1'b0;
            case (r_rx_state)
                R_IDLE: begin
                    r_clk_cnt <= '0;
                    if (!w_rx) begin
                        r_rx_state <= R_START;
                    end
                end
                R_START: begin
                    // Re-check the start bit half a bit later to reject glitches.
                    if (r_clk_cnt == HALF_LAST) begin
                        r_clk_cnt <= '0;
                        r_bit_idx <= 3'd0;
                        r_rx_state <= w_rx ? R_IDLE : R_DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CW'(1);
                    end
                end
                R_DATA: begin
                    if (r_clk_cnt == BIT_LAST) begin
                        r_clk_cnt <= '0;
                        r_shift   <= {w_rx, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_rx_state <= R_STOP;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CW'(1);
                    end
                end
                R_STOP: begin
                    if (r_clk_cnt == BIT_LAST) begin
                        r_clk_cnt <= '0;
                        if (w_rx) begin
                            r_byte_stb <= 1'b1;
                            r_byte     <= r_shift;
                            r_rx_state <= R_IDLE;
                        end else begin
                            // A low stop bit may be a break; wait for idle line.
                            r_frm_err  <= 1'b1;
                            r_rx_state <= R_WAIT;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CW'(1);
                    end
                end
                R_WAIT: begin
                    r_clk_cnt <= '0;
                    if (w_rx) begin
                        r_rx_state <= R_IDLE;
                    end
                end
                default: begin
                    r_rx_state <= R_IDLE;
                    r_clk_cnt  <= '0;
                end
            endcase
        end
    end

    // Buffer write decode: plain payload bytes in P_BODY, unstuffed byte in P_ESC.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_data = r_byte;
        if (r_byte_stb && !w_full) begin
            case (r_p_state)
                P_BODY: begin
                    w_wr_en = !(w_is_som || w_is_eom || w_is_esc);
                end
                P_ESC: begin
                    w_wr_en   = 1'b1;
                    w_wr_data = r_byte ^ UNSTUFF;
                end
                default: begin
                    w_wr_en = 1'b0;
                end
            endcase
        end else begin
            w_wr_en = 1'b0;
        end
    end

    // Payload buffer write port; contents are only read after being written.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= w_wr_data;
        end
    end

    // Frame parser and drain engine with registered stream/status outputs.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_p_state    <= P_HUNT;
            r_count      <= '0;
            r_rd_ptr     <= '0;
            r_frame_len  <= '0;
            r_frame_done <= 1'b0;
            r_err_ovf    <= 1'b0;
            r_err_drop   <= 1'b0;
            r_busy       <= 1'b0;
            r_m_data     <= 8'h00;
            r_m_valid    <= 1'b0;
            r_m_last     <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_err_ovf    <= 1'b0;
            r_err_drop   <= 1'b0;
            case (r_p_state)
                P_HUNT: begin
                    if (r_byte_stb && w_is_som) begin
                        r_p_state <= P_BODY;
                        r_count   <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                P_BODY: begin
                    if (r_frm_err) begin
                        r_p_state <= P_HUNT;
                        r_busy    <= 1'b0;
                    end else if (r_byte_stb) begin
                        if (w_is_som) begin
                            r_count <= '0;
                        end else if (w_is_eom) begin
                            if (r_count == '0) begin
                                r_p_state <= P_HUNT;
                                r_busy    <= 1'b0;
                            end else begin
                                r_frame_len  <= LW'(r_count);
                                r_frame_done <= 1'b1;
                                r_rd_ptr     <= '0;
                                r_p_state    <= P_DRAIN;
                            end
                        end else if (w_is_esc) begin
                            r_p_state <= P_ESC;
                        end else if (w_full) begin
                            r_err_ovf <= 1'b1;
                            r_p_state <= P_HUNT;
                            r_busy    <= 1'b0;
                        end else begin
                            r_count <= r_count + CNT_W'(1);
                        end
                    end
                end
                P_ESC: begin
                    if (r_frm_err) begin
                        r_p_state <= P_HUNT;
                        r_busy    <= 1'b0;
                    end else if (r_byte_stb) begin
                        if (w_full) begin
                            r_err_ovf <= 1'b1;
                            r_p_state <= P_HUNT;
                            r_busy    <= 1'b0;
                        end else begin
                            r_count   <= r_count + CNT_W'(1);
                            r_p_state <= P_BODY;
                        end
                    end
                end
                P_DRAIN: begin
                    // The buffer is not double-buffered: anything arriving now is lost.
                    if (r_byte_stb) begin
                        r_err_drop <= 1'b1;
                    end
                    if (!r_m_valid) begin
                        // First cycle of the drain: present buffer[0].
                        r_m_data  <= w_rd_byte;
                        r_m_valid <= 1'b1;
                        r_m_last  <= w_rd_last;
                        r_rd_ptr  <= r_rd_ptr + PW'(1);
                    end else if (w_hs) begin
                        if (r_m_last) begin
                            r_m_valid <= 1'b0;
                            r_m_last  <= 1'b0;
                            r_p_state <= P_HUNT;
                            r_busy    <= 1'b0;
                        end else begin
                            r_m_data <= w_rd_byte;
                            r_m_last <= w_rd_last;
                            r_rd_ptr <= r_rd_ptr + PW'(1);
                        end
                    end
                end
                default: begin
                    r_p_state <= P_HUNT;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign m.m_data     = r_m_data;
    assign m.m_valid    = r_m_valid;
    assign m.m_last     = r_m_last;
    assign frame_len    = r_frame_len;
    assign frame_done   = r_frame_done;
    assign err_framing  = r_frm_err;
    assign err_overflow = r_err_ovf;
    assign err_dropped  = r_err_drop;
    assign busy         = r_busy;

endmodule
